// File: rtl/rom_fetch_queue.sv
// Fetch stage feeding decode from a 1-cycle-latency ROM through a small FIFO.
// Define FETCH_BYPASS_EN to forward returning ROM words straight to decode when the FIFO is empty.
module rom_fetch_queue #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [DATA_W-1:0]          rom_dout,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DATA_W-1:0]          instr_data,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]     queue_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [ADDR_W-1:0] pcs_d [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [LW-1:0]     cnt_q, cnt_d;

  logic issue, byp, push, pop;

  assign rom_address = pc_q;
  assign queue_level = cnt_q;

  always_comb begin
    pc_d   = pc_q;
    infl_d = 1'b0;
    ipc_d  = ipc_q;
    dat_d  = dat_q;
    pcs_d  = pcs_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;

`ifdef FETCH_BYPASS_EN
    byp = !redirect_valid && infl_q && (cnt_q == '0);
`else
    byp = 1'b0;
`endif

    // Credit check ignores same-cycle pops so a push can never hit a full FIFO.
    issue = !redirect_valid &&
            ((cnt_q + LW'(infl_q)) < LW'(DEPTH));

    instr_valid = !redirect_valid && ((cnt_q != '0) || byp);
    instr_data  = byp ? rom_dout : dat_q[rd_q];
    instr_pc    = byp ? ipc_q    : pcs_q[rd_q];

    pop  = !redirect_valid && instr_ready && (cnt_q != '0);
    push = !redirect_valid && infl_q && !(byp && instr_ready);

    if (redirect_valid) begin
      pc_d  = redirect_pc;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (issue) begin
        infl_d = 1'b1;
        ipc_d  = pc_q;
        pc_d   = pc_q + ADDR_W'(1);
      end
      if (push) begin
        dat_d[wr_q] = rom_dout;
        pcs_d[wr_q] = ipc_q;
        wr_d        = wr_q + PW'(1);
      end
      if (pop)
        rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= ADDR_W'(RESET_PC);
      infl_q <= 1'b0;
      ipc_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
      ipc_q  <= ipc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      pcs_q  <= pcs_d;
    end
  end

endmodule

// File: tb/tb_rom_fetch_queue.sv
// Randomized bench for rom_fetch_queue: ROM model mem[a]=a*3 plus an
// expected-next-PC model checked on every cycle, with directed latency/boundary cases.
module tb_rom_fetch_queue;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dout = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b1;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [2:0]        queue_level;

  int n_chk  = 0;
  int n_fail = 0;
  logic [ADDR_W-1:0] exp_pc = '0;

  rom_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_address(rom_address), .rom_dout(rom_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .queue_level(queue_level)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) * 3;
  endfunction

  always @(posedge clk) rom_dout <= rom_word(rom_address);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Head of the queue must always be the next PC in program order.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = '0;
    end else begin
      chk("level_le_depth", 32'(queue_level <= 3'(DEPTH)), 1);
      if (redirect_valid) begin
        chk("valid_low_on_redirect", 32'(instr_valid), 0);
        exp_pc = redirect_pc;
      end else if (instr_valid) begin
        chk("head_pc", 32'(instr_pc), 32'(exp_pc));
        chk("head_data", instr_data, rom_word(instr_pc));
        if (instr_ready) exp_pc = exp_pc + 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  int cnt;
  logic [ADDR_W-1:0] a_prev;
  logic [ADDR_W-1:0] got [4];

  initial begin
    // 1: reset state, first-word latency, streaming
    step();
    step();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_level", 32'(queue_level), 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_addr", 32'(rom_address), 0);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_valid && n < 10);
    chk("first_latency", n, FIRST_LAT);
    chk("w0_pc", 32'(instr_pc), 0);
    chk("w0_data", instr_data, 0);
    step();
    chk("w1_pc", 32'(instr_pc), 1);
    chk("w1_data", instr_data, 3);
    step();
    chk("w2_pc", 32'(instr_pc), 2);
    chk("w2_data", instr_data, 6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) cnt++;
      step();
    end
    chk("throughput", cnt, 20);

    // 2: backpressure saturates the queue and stops issue
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    a_prev = rom_address;
    step();
    step();
    chk("sat_level", 32'(queue_level), DEPTH);
    chk("issue_stopped", 32'(rom_address), 32'(a_prev));
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // 3: redirect with 3 queued words and one in flight
    instr_ready = 1'b0;
    n = 0;
    while (queue_level != 3'd3 && n < 20) begin
      step();
      n++;
    end
    chk("level_reached_3", 32'(queue_level), 3);
    redirect_valid = 1'b1;
    redirect_pc = 10'h200;
    #1;
    chk("redir_valid_comb", 32'(instr_valid), 0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    n = 1;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    chk("redir_latency", n, FIRST_LAT + 1);
    chk("redir_pc", 32'(instr_pc), 32'h200);
    chk("redir_data", instr_data, 32'h600);

    // 4: wrap-around from top of address space
    step();
    redirect_valid = 1'b1;
    redirect_pc = 10'h3FE;
    step();
    redirect_valid = 1'b0;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 20) begin
      if (instr_valid && instr_ready) begin
        got[cnt] = instr_pc;
        cnt++;
      end
      step();
      n++;
    end
    chk("wrap_count", cnt, 4);
    chk("wrap_pc0", 32'(got[0]), 32'h3FE);
    chk("wrap_pc1", 32'(got[1]), 32'h3FF);
    chk("wrap_pc2", 32'(got[2]), 32'h000);
    chk("wrap_pc3", 32'(got[3]), 32'h001);

    // 5: random backpressure and redirects
    for (int i = 0; i < 10000; i++) begin
      instr_ready    = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = ADDR_W'($urandom);
      step();
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // 6: asynchronous reset mid-stream
    chk("pre_rst_valid", 32'(instr_valid), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 0);
    chk("async_rst_level", 32'(queue_level), 0);
    chk("async_rst_addr", 32'(rom_address), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_valid && n < 10);
    chk("restart_latency", n, FIRST_LAT);
    chk("restart_pc", 32'(instr_pc), 0);
    chk("restart_data", instr_data, 0);
    for (int i = 0; i < 5; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
